// File: rtl/Exception_Pkg.sv
// Exception cause codes raised by EX-stage units.
// Encoding follows the RISC-V mcause numbering.
package Exception_Pkg;

  localparam logic [3:0] CAUSE_LOAD_MISALIGNED  = 4'd4;
  localparam logic [3:0] CAUSE_LOAD_FAULT       = 4'd5;
  localparam logic [3:0] CAUSE_STORE_MISALIGNED = 4'd6;
  localparam logic [3:0] CAUSE_STORE_FAULT      = 4'd7;

endpackage

// File: rtl/RV32I_Inst_Pkg.sv
// RV32I load/store funct3 encodings and access-width helper.
// Shared by the EX-stage load/store path.
package RV32I_Inst_Pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    WID_B,
    WID_H,
    WID_W
  } mem_width_e;

  // Unused encodings (3,6,7) fall through to word width.
  function automatic mem_width_e f3_width(input logic [2:0] f3);
    unique case (f3[1:0])
      F3_B[1:0]: return WID_B;
      F3_H[1:0]: return WID_H;
      default:   return WID_W;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering for stores, extract/extend for loads,
// and alignment check. Purely combinational.
module lsu_lane_align
  import RV32I_Inst_Pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_sdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic        o_misaligned,
  input  logic [2:0]  i_ld_funct3,
  input  logic [1:0]  i_ld_off,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_ld_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_uns;

  always_comb begin
    o_be         = 4'b1111;
    o_wdata      = i_sdata;
    o_misaligned = 1'b0;
    unique case (f3_width(i_funct3))
      WID_B: begin
        o_be    = 4'b0001 << i_off;
        o_wdata = {4{i_sdata[7:0]}};
      end
      WID_H: begin
        o_be         = i_off[1] ? 4'b1100 : 4'b0011;
        o_wdata      = {2{i_sdata[15:0]}};
        o_misaligned = i_off[0];
      end
      default: begin
        o_misaligned = |i_off;
      end
    endcase
  end

  assign w_byte = i_rdata[{i_ld_off, 3'b000} +: 8];
  assign w_half = i_ld_off[1] ? i_rdata[31:16] : i_rdata[15:0];
  assign w_uns  = i_ld_funct3[2];

  always_comb begin
    o_ld_data = i_rdata;
    unique case (f3_width(i_ld_funct3))
      WID_B:   o_ld_data = {{24{w_byte[7] & ~w_uns}}, w_byte};
      WID_H:   o_ld_data = {{16{w_half[15] & ~w_uns}}, w_half};
      default: o_ld_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/ex_lsu.sv
// EX-stage load/store unit: one 32-bit bus transaction per
// memory instruction, stalling the pipeline until it completes.
module ex_lsu
  import RV32I_Inst_Pkg::*;
  import Exception_Pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_sync,
  input  logic        flush,
  input  logic        stall_n,
  input  logic        ram_load_access_id_ex,
  input  logic        ram_store_access_id_ex,
  input  logic [31:0] ram_load_addr_id_ex,
  input  logic [31:0] ram_store_addr_id_ex,
  input  logic [31:0] ram_store_data_id_ex,
  input  logic [31:0] instruction_id_ex,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata,
  input  logic        bus_err,
  output logic        stall_req,
  output logic [31:0] mem_rd_data_ex,
  output logic        mem_rd_valid_ex,
  output logic        exception_lsu_raise,
  output logic [3:0]  exception_lsu_cause,
  output logic [31:0] exception_lsu_tval
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_RESP,
    S_DONE,
    S_FAULT,
    S_DRAIN
  } lsu_state_e;

  lsu_state_e r_state, w_next;

  logic [CW-1:0] r_cnt;
  logic          r_load;
  logic [2:0]    r_f3;
  logic [31:0]   r_addr;
  logic [3:0]    r_be;
  logic [31:0]   r_wdata;
  logic [31:0]   r_rdata;
  logic [3:0]    r_cause;
  logic [31:0]   r_tval;

  logic        w_load;
  logic        w_access;
  logic        w_idle;
  logic [31:0] w_addr;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic        w_mis;
  logic [31:0] w_ld_data;
  logic        w_tmo;
  logic        w_fault;
  logic [3:0]  w_cause;
  logic        w_rd_latch;
  logic        w_unused;

  assign w_load   = ram_load_access_id_ex;
  assign w_access = ram_load_access_id_ex | ram_store_access_id_ex;
  assign w_addr   = w_load ? ram_load_addr_id_ex : ram_store_addr_id_ex;
  assign w_idle   = (r_state == S_IDLE);
  assign w_tmo    = (r_cnt == CW'(TIMEOUT_CYCLES - 1));
  assign w_unused = ^{instruction_id_ex[31:15], instruction_id_ex[11:0]};

  lsu_lane_align u_align (
    .i_funct3     (instruction_id_ex[14:12]),
    .i_off        (w_addr[1:0]),
    .i_sdata      (ram_store_data_id_ex),
    .o_be         (w_be),
    .o_wdata      (w_wdata),
    .o_misaligned (w_mis),
    .i_ld_funct3  (r_f3),
    .i_ld_off     (r_addr[1:0]),
    .i_rdata      (bus_rdata),
    .o_ld_data    (w_ld_data)
  );

  // First request cycle drives straight from ID->EX; later ones replay the latch.
  assign bus_we    = w_idle ? ~w_load : ~r_load;
  assign bus_addr  = w_idle ? {w_addr[31:2], 2'b00} : {r_addr[31:2], 2'b00};
  assign bus_be    = w_idle ? w_be : r_be;
  assign bus_wdata = w_idle ? w_wdata : r_wdata;

  always_comb begin
    w_next     = r_state;
    bus_req    = 1'b0;
    stall_req  = 1'b0;
    w_fault    = 1'b0;
    w_cause    = CAUSE_LOAD_FAULT;
    w_rd_latch = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_access && !flush) begin
          stall_req = 1'b1;
          if (w_mis) begin
            w_next  = S_FAULT;
            w_fault = 1'b1;
            w_cause = w_load ? CAUSE_LOAD_MISALIGNED
                             : CAUSE_STORE_MISALIGNED;
          end else begin
            bus_req = 1'b1;
            if (!bus_gnt) begin
              w_next = S_REQ;
            end else if (w_load) begin
              w_next = S_RESP;
            end else if (bus_err) begin
              w_next  = S_FAULT;
              w_fault = 1'b1;
              w_cause = CAUSE_STORE_FAULT;
            end else begin
              w_next = S_DONE;
            end
          end
        end
      end
      S_REQ: begin
        bus_req   = 1'b1;
        stall_req = 1'b1;
        if (flush) begin
          w_next = (bus_gnt && r_load) ? S_DRAIN : S_IDLE;
        end else if (bus_gnt) begin
          if (r_load) begin
            w_next = S_RESP;
          end else if (bus_err) begin
            w_next  = S_FAULT;
            w_fault = 1'b1;
            w_cause = CAUSE_STORE_FAULT;
          end else begin
            w_next = S_DONE;
          end
        end else if (w_tmo) begin
          w_next  = S_FAULT;
          w_fault = 1'b1;
          w_cause = r_load ? CAUSE_LOAD_FAULT : CAUSE_STORE_FAULT;
        end
      end
      S_RESP: begin
        stall_req = 1'b1;
        if (flush) begin
          w_next = bus_rvalid ? S_IDLE : S_DRAIN;
        end else if (bus_rvalid) begin
          if (bus_err) begin
            w_next  = S_FAULT;
            w_fault = 1'b1;
          end else begin
            w_next     = S_DONE;
            w_rd_latch = 1'b1;
          end
        end else if (w_tmo) begin
          w_next  = S_FAULT;
          w_fault = 1'b1;
        end
      end
      S_DONE, S_FAULT: begin
        if (flush || stall_n) w_next = S_IDLE;
      end
      S_DRAIN: begin
        stall_req = 1'b1;
        if (bus_rvalid) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_sync) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_load  <= 1'b0;
      r_f3    <= '0;
      r_addr  <= '0;
      r_be    <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_cause <= '0;
      r_tval  <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_REQ || r_state == S_RESP) r_cnt <= r_cnt + 1'b1;
      else r_cnt <= '0;
      if (w_idle) begin
        r_load  <= w_load;
        r_f3    <= instruction_id_ex[14:12];
        r_addr  <= w_addr;
        r_be    <= w_be;
        r_wdata <= w_wdata;
      end
      if (w_next == S_IDLE) begin
        r_rdata <= '0;
        r_cause <= '0;
        r_tval  <= '0;
      end else begin
        if (w_rd_latch) r_rdata <= w_ld_data;
        if (w_fault) begin
          r_cause <= w_cause;
          r_tval  <= w_idle ? w_addr : r_addr;
        end
      end
    end
  end

  assign mem_rd_data_ex      = r_rdata;
  assign mem_rd_valid_ex     = (r_state == S_DONE) && r_load;
  assign exception_lsu_raise = (r_state == S_FAULT);
  assign exception_lsu_cause = r_cause;
  assign exception_lsu_tval  = r_tval;

endmodule

// File: tb/tb_ex_lsu.sv
// Bench for ex_lsu: directed scenarios plus randomized
// loads/stores checked against a byte-level reference model.
module tb_ex_lsu;

  logic        clk = 1'b0;
  logic        rst_sync, flush, stall_n;
  logic        ld_acc, st_acc;
  logic [31:0] ld_addr, st_addr, st_data, instr;
  logic        bus_req, bus_we, bus_gnt, bus_rvalid, bus_err;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;
  logic        stall_req, rd_valid, ex_raise;
  logic [31:0] rd_data, ex_tval;
  logic [3:0]  ex_cause;

  always #5 clk = ~clk;

  ex_lsu #(.TIMEOUT_CYCLES(255)) dut (
    .clk                    (clk),
    .rst_sync               (rst_sync),
    .flush                  (flush),
    .stall_n                (stall_n),
    .ram_load_access_id_ex  (ld_acc),
    .ram_store_access_id_ex (st_acc),
    .ram_load_addr_id_ex    (ld_addr),
    .ram_store_addr_id_ex   (st_addr),
    .ram_store_data_id_ex   (st_data),
    .instruction_id_ex      (instr),
    .bus_req                (bus_req),
    .bus_we                 (bus_we),
    .bus_addr               (bus_addr),
    .bus_be                 (bus_be),
    .bus_wdata              (bus_wdata),
    .bus_gnt                (bus_gnt),
    .bus_rvalid             (bus_rvalid),
    .bus_rdata              (bus_rdata),
    .bus_err                (bus_err),
    .stall_req              (stall_req),
    .mem_rd_data_ex         (rd_data),
    .mem_rd_valid_ex        (rd_valid),
    .exception_lsu_raise    (ex_raise),
    .exception_lsu_cause    (ex_cause),
    .exception_lsu_tval     (ex_tval)
  );

  int total = 0;
  int bad   = 0;

  bit          o_done, o_req_seen, o_we, o_valid, o_raise, o_req_end;
  logic [31:0] o_addr, o_wdata, o_data, o_tval;
  logic [3:0]  o_be, o_cause;
  int          o_stall, o_reqc;

  // ---- reference model ----
  function automatic int nbytes(input logic [2:0] f3);
    if (f3[1:0] == 2'd0) return 1;
    if (f3[1:0] == 2'd1) return 2;
    return 4;
  endfunction

  function automatic bit m_mis(input logic [31:0] a, input logic [2:0] f3);
    return (a % nbytes(f3)) != 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [31:0] a, input logic [2:0] f3);
    int n = nbytes(f3);
    return 4'(((1 << n) - 1) << (a % 4));
  endfunction

  function automatic logic [31:0] m_wdata(input logic [31:0] d, input logic [2:0] f3);
    int n = nbytes(f3);
    if (n == 1) return (d & 32'hFF) * 32'h0101_0101;
    if (n == 2) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] rd, input logic [31:0] a,
                                        input logic [2:0] f3);
    int n = nbytes(f3);
    logic [31:0] mask, v;
    if (n == 4) return rd;
    mask = (32'h1 << (8 * n)) - 1;
    v = (rd >> (8 * (a % 4))) & mask;
    if (!f3[2] && v[8*n-1]) v = v | ~mask;
    return v;
  endfunction

  // ---- drivers ----
  task automatic idle_inputs();
    flush = 1'b0; ld_acc = 1'b0; st_acc = 1'b0;
    bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_err = 1'b0;
  endtask

  task automatic do_op(input bit ld, input logic [31:0] a, input logic [31:0] d,
                       input logic [2:0] f3, input int gdly, input int rdly,
                       input logic [31:0] rd, input bit err);
    int reqc = 0;
    int g = 0;
    bit gr = 1'b0;
    @(negedge clk);
    ld_acc = ld; st_acc = !ld;
    ld_addr = ld ? a : ~a;
    st_addr = ld ? ~a : a;
    st_data = d;
    instr = {17'h0, f3, 12'h003};
    o_done = 0; o_req_seen = 0; o_stall = 0;
    o_valid = 0; o_raise = 0;
    for (int c = 0; c < 400; c++) begin
      #1;
      if (c > 0 && !stall_req) begin
        o_done = 1; o_valid = rd_valid; o_data = rd_data;
        o_raise = ex_raise; o_cause = ex_cause; o_tval = ex_tval;
        o_req_end = bus_req;
        break;
      end
      if (stall_req) o_stall++;
      if (bus_req) begin
        if (!o_req_seen) begin
          o_addr = bus_addr; o_be = bus_be; o_wdata = bus_wdata; o_we = bus_we;
        end
        o_req_seen = 1;
        if (reqc == gdly) begin
          bus_gnt = 1'b1; bus_err = err && !ld; gr = 1'b1; g = c;
        end
        reqc++;
      end
      if (gr && ld && c - g == rdly) begin
        bus_rvalid = 1'b1; bus_rdata = rd; bus_err = err;
      end
      @(negedge clk);
      bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_err = 1'b0;
    end
    o_reqc = reqc;
    @(negedge clk);
    idle_inputs();
  endtask

  // ---- scenarios ----
  task automatic test_reset();
    idle_inputs(); stall_n = 1'b1; rst_sync = 1'b1;
    ld_addr = 0; st_addr = 0; st_data = 0; instr = 0; bus_rdata = 0;
    repeat (3) @(negedge clk);
    rst_sync = 1'b0;
    #1;
    total++;
    if ({bus_req, stall_req, rd_valid, ex_raise} !== 4'b0000) begin
      bad++; $display("FAIL reset_ctrl got %b want 0000", {bus_req, stall_req, rd_valid, ex_raise});
    end
    total++;
    if ({rd_data, ex_cause, ex_tval} !== 68'h0) begin
      bad++; $display("FAIL reset_data got %h/%h/%h want 0", rd_data, ex_cause, ex_tval);
    end
  endtask

  task automatic test_sw();
    do_op(0, 32'h1000, 32'hDEADBEEF, 3'd2, 0, 1, 0, 0);
    total++;
    if (!o_done || o_be !== 4'b1111 || o_wdata !== 32'hDEADBEEF || o_we !== 1'b1) begin
      bad++; $display("FAIL sw_lanes got be=%b wd=%h we=%b want 1111 deadbeef 1", o_be, o_wdata, o_we);
    end
    total++;
    if (o_stall != 1 || o_raise || o_valid) begin
      bad++; $display("FAIL sw_timing got stall=%0d raise=%b valid=%b want 1 0 0", o_stall, o_raise, o_valid);
    end
  endtask

  task automatic test_lb();
    do_op(1, 32'h2003, 0, 3'd0, 0, 2, 32'h80FFFFFF, 0);
    total++;
    if (!o_valid || o_data !== 32'hFFFFFF80 || o_stall != 3) begin
      bad++; $display("FAIL lb got v=%b d=%h stall=%0d want 1 ffffff80 3", o_valid, o_data, o_stall);
    end
    total++;
    if (o_addr !== 32'h2000 || o_we !== 1'b0) begin
      bad++; $display("FAIL lb_addr got %h we=%b want 00002000 0", o_addr, o_we);
    end
    do_op(1, 32'h2003, 0, 3'd4, 0, 2, 32'h80FFFFFF, 0);
    total++;
    if (!o_valid || o_data !== 32'h00000080) begin
      bad++; $display("FAIL lbu got v=%b d=%h want 1 00000080", o_valid, o_data);
    end
  endtask

  task automatic test_sh();
    do_op(0, 32'h3002, 32'h1234, 3'd1, 1, 1, 0, 0);
    total++;
    if (o_addr !== 32'h3000 || o_be !== 4'b1100 || o_wdata !== 32'h12341234) begin
      bad++; $display("FAIL sh got a=%h be=%b wd=%h want 3000 1100 12341234", o_addr, o_be, o_wdata);
    end
  endtask

  task automatic test_misaligned();
    do_op(1, 32'h4001, 0, 3'd2, 0, 1, 0, 0);
    total++;
    if (o_req_seen || !o_raise || o_cause !== 4'd4 || o_tval !== 32'h4001) begin
      bad++; $display("FAIL lw_mis got req=%b r=%b c=%0d t=%h want 0 1 4 4001", o_req_seen, o_raise, o_cause, o_tval);
    end
    do_op(0, 32'h4001, 0, 3'd1, 0, 1, 0, 0);
    total++;
    if (o_req_seen || !o_raise || o_cause !== 4'd6 || o_tval !== 32'h4001) begin
      bad++; $display("FAIL sh_mis got req=%b r=%b c=%0d t=%h want 0 1 6 4001", o_req_seen, o_raise, o_cause, o_tval);
    end
  endtask

  task automatic test_timeout();
    do_op(1, 32'h5000, 0, 3'd2, 1000, 1, 0, 0);
    total++;
    if (!o_done || !o_raise || o_cause !== 4'd5 || o_req_end) begin
      bad++; $display("FAIL timeout got done=%b r=%b c=%0d req=%b want 1 1 5 0", o_done, o_raise, o_cause, o_req_end);
    end
    total++;
    if (o_reqc < 255 || o_reqc > 257) begin
      bad++; $display("FAIL timeout_len got %0d req cycles want 255..257", o_reqc);
    end
    do_op(0, 32'h5004, 32'h55, 3'd2, 0, 1, 0, 1);
    total++;
    if (!o_raise || o_cause !== 4'd7 || o_tval !== 32'h5004) begin
      bad++; $display("FAIL st_err got r=%b c=%0d t=%h want 1 7 5004", o_raise, o_cause, o_tval);
    end
  endtask

  task automatic test_flush_resp();
    bit vseen = 0;
    @(negedge clk);
    ld_acc = 1; st_acc = 0; ld_addr = 32'h6000; instr = {17'h0, 3'd2, 12'h003};
    #1; bus_gnt = 1'b1;
    @(negedge clk); bus_gnt = 0; flush = 1;
    @(negedge clk); flush = 0; ld_acc = 0;
    #1; vseen |= rd_valid;
    total++;
    if (stall_req !== 1'b1) begin
      bad++; $display("FAIL drain_stall1 got %b want 1", stall_req);
    end
    @(negedge clk); #1; vseen |= rd_valid;
    total++;
    if (stall_req !== 1'b1) begin
      bad++; $display("FAIL drain_stall2 got %b want 1", stall_req);
    end
    bus_rvalid = 1; bus_rdata = 32'hCAFEF00D;
    @(negedge clk); bus_rvalid = 0; #1; vseen |= rd_valid;
    total++;
    if (stall_req !== 1'b0 || vseen || ex_raise !== 1'b0) begin
      bad++; $display("FAIL drain_end got stall=%b v=%b r=%b want 0 0 0", stall_req, vseen, ex_raise);
    end
  endtask

  task automatic test_rst_req();
    @(negedge clk);
    st_acc = 1; ld_acc = 0; st_addr = 32'h7000; st_data = 1; instr = {17'h0, 3'd2, 12'h003};
    @(negedge clk); #1;
    total++;
    if (bus_req !== 1'b1 || bus_addr !== 32'h7000) begin
      bad++; $display("FAIL req_hold got req=%b a=%h want 1 7000", bus_req, bus_addr);
    end
    rst_sync = 1;
    @(negedge clk); rst_sync = 0; st_acc = 0; bus_rvalid = 1; #1;
    total++;
    if (bus_req !== 1'b0 || stall_req !== 1'b0) begin
      bad++; $display("FAIL rst_req got req=%b stall=%b want 0 0", bus_req, stall_req);
    end
    @(negedge clk); bus_rvalid = 0; #1;
    total++;
    if (rd_valid !== 1'b0 || ex_raise !== 1'b0) begin
      bad++; $display("FAIL rst_rvalid got v=%b r=%b want 0 0", rd_valid, ex_raise);
    end
  endtask

  task automatic test_random();
    logic [2:0] lf3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    for (int i = 0; i < 60; i++) begin
      bit ld = 1'($urandom);
      logic [2:0] f3 = ld ? lf3[$urandom_range(0, 4)] : 3'($urandom_range(0, 2));
      int n = nbytes(f3);
      logic [31:0] a = $urandom & 32'hFFFF_FFFC;
      logic [31:0] d = $urandom;
      logic [31:0] rd = $urandom;
      int gd = $urandom_range(0, 3);
      int rdl = $urandom_range(1, 3);
      bit err = ($urandom_range(0, 7) == 0);
      bit mis;
      if ($urandom_range(0, 3) == 0) a = a + $urandom_range(0, 3);
      else a = a + n * $urandom_range(0, (4 / n) - 1);
      mis = m_mis(a, f3);
      do_op(ld, a, d, f3, gd, rdl, rd, err);
      total++;
      if (mis) begin
        if (o_req_seen || !o_raise || o_cause !== (ld ? 4'd4 : 4'd6) || o_tval !== a) begin
          bad++; $display("FAIL rnd_mis #%0d got req=%b r=%b c=%0d t=%h want 0 1 %0d %h",
                          i, o_req_seen, o_raise, o_cause, o_tval, ld ? 4 : 6, a);
        end
      end else if (o_addr !== (a & 32'hFFFF_FFFC) || o_we !== !ld
                   || (!ld && (o_be !== m_be(a, f3) || o_wdata !== m_wdata(d, f3)))) begin
        bad++; $display("FAIL rnd_bus #%0d got a=%h we=%b be=%b wd=%h want %h %b %b %h",
                        i, o_addr, o_we, o_be, o_wdata, a & 32'hFFFF_FFFC, !ld, m_be(a, f3), m_wdata(d, f3));
      end
      if (!mis) begin
        total++;
        if (err) begin
          if (!o_raise || o_cause !== (ld ? 4'd5 : 4'd7) || o_tval !== a || o_valid) begin
            bad++; $display("FAIL rnd_err #%0d got r=%b c=%0d t=%h v=%b", i, o_raise, o_cause, o_tval, o_valid);
          end
        end else if (o_raise || o_valid !== ld || (ld && o_data !== m_load(rd, a, f3))) begin
          bad++; $display("FAIL rnd_res #%0d got r=%b v=%b d=%h want 0 %b %h",
                          i, o_raise, o_valid, o_data, ld, m_load(rd, a, f3));
        end
        total++;
        if (o_stall != (ld ? gd + rdl + 1 : gd + 1)) begin
          bad++; $display("FAIL rnd_stall #%0d got %0d want %0d", i, o_stall, ld ? gd + rdl + 1 : gd + 1);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_sw();
    test_lb();
    test_sh();
    test_misaligned();
    test_timeout();
    test_flush_resp();
    test_rst_req();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
